// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and fills the
// IF/ID register, honouring control-unit redirects, stalls and misaligned targets.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'hBFC00000),
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      PCsrc,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] alu_result,
  input  logic            stall,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [XLEN-1:0] pc_f,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            misalign_err,
  output logic [XLEN-1:0] err_pc,
  output logic [31:0]     fetch_count
);

  localparam int unsigned InstrW = 32;
  localparam int unsigned CountW = 32;

  localparam logic [1:0] SrcBranch = 2'd1;
  localparam logic [1:0] SrcJalr   = 2'd2;

  // Architectural state
  logic [XLEN-1:0]   pcF;
  logic [InstrW-1:0] instrD;
  logic [XLEN-1:0]   pcD;
  logic [XLEN-1:0]   pcPlus4D;
  logic              validD;
  logic              misalignErr;
  logic [XLEN-1:0]   errPc;
  logic [CountW-1:0] fetchCount;

  // Next-state values
  logic [XLEN-1:0]   pcFNext;
  logic [InstrW-1:0] instrDNext;
  logic [XLEN-1:0]   pcDNext;
  logic [XLEN-1:0]   pcPlus4DNext;
  logic              validDNext;
  logic              misalignErrNext;
  logic [XLEN-1:0]   errPcNext;
  logic [CountW-1:0] fetchCountNext;

  logic [XLEN-1:0]   target;
  logic              redirect;
  logic [XLEN-1:0]   pcPlus4;

  // Redirect target selection; encoding 3 is reserved and behaves as sequential.
  always_comb begin
    target   = '0;
    redirect = 1'b0;
    case (PCsrc)
      SrcBranch: begin
        target   = branch_target;
        redirect = 1'b1;
      end
      SrcJalr: begin
        target   = {alu_result[XLEN-1:1], 1'b0};
        redirect = 1'b1;
      end
      default: begin
        target   = '0;
        redirect = 1'b0;
      end
    endcase
  end

  assign pcPlus4 = pcF + XLEN'(4);

  // Next-state logic: redirect beats stall, stall beats sequential fetch.
  always_comb begin
    pcFNext         = pcF;
    instrDNext      = instrD;
    pcDNext         = pcD;
    pcPlus4DNext    = pcPlus4D;
    validDNext      = validD;
    misalignErrNext = misalignErr;
    errPcNext       = errPc;
    fetchCountNext  = fetchCount;

    if (redirect) begin
      pcFNext    = {target[XLEN-1:2], 2'b00};
      instrDNext = NOP_INSTR;
      validDNext = 1'b0;
      // Only the first misaligned target is captured until reset.
      if (target[1] && !misalignErr) begin
        misalignErrNext = 1'b1;
        errPcNext       = target;
      end
    end else if (!stall) begin
      pcFNext        = pcPlus4;
      instrDNext     = imem_data;
      pcDNext        = pcF;
      pcPlus4DNext   = pcPlus4;
      validDNext     = 1'b1;
      fetchCountNext = fetchCount + CountW'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF         <= RESET_PC;
      instrD      <= NOP_INSTR;
      pcD         <= '0;
      pcPlus4D    <= '0;
      validD      <= 1'b0;
      misalignErr <= 1'b0;
      errPc       <= '0;
      fetchCount  <= '0;
    end else begin
      pcF         <= pcFNext;
      instrD      <= instrDNext;
      pcD         <= pcDNext;
      pcPlus4D    <= pcPlus4DNext;
      validD      <= validDNext;
      misalignErr <= misalignErrNext;
      errPc       <= errPcNext;
      fetchCount  <= fetchCountNext;
    end
  end

  assign imem_addr    = pcF;
  assign pc_f         = pcF;
  assign instr_d      = instrD;
  assign pc_d         = pcD;
  assign pc_plus4_d   = pcPlus4D;
  assign valid_d      = validD;
  assign misalign_err = misalignErr;
  assign err_pc       = errPc;
  assign fetch_count  = fetchCount;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plan steps followed by random
// redirect/stall traffic, all compared against a behavioural model of the stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] RPC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCsrc;
  logic [31:0] branch_target;
  logic [31:0] alu_result;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_err;
  logic [31:0] err_pc;
  logic [31:0] fetch_count;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .branch_target(branch_target),
    .alu_result(alu_result), .stall(stall), .imem_addr(imem_addr),
    .imem_data(imem_data), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .misalign_err(misalign_err),
    .err_pc(err_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // ROM: either a fixed word or an address-derived pattern
  logic        useConst = 1'b1;
  logic [31:0] constWord = 32'h00A00093;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E3779B9;
  endfunction

  always_comb imem_data = useConst ? constWord : romWord(imem_addr);

  // Behavioural model of the architectural state
  longint unsigned mPc, mPcD, mPcP4, mErrPc, mCount;
  logic [31:0]     mInstr;
  bit              mValid, mErr;

  int nAsserts = 0;
  int nFails   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    check({tag, ".pc_f"},        pc_f,         32'(mPc));
    check({tag, ".imem_addr"},   imem_addr,    32'(mPc));
    check({tag, ".instr_d"},     instr_d,      mInstr);
    check({tag, ".pc_d"},        pc_d,         32'(mPcD));
    check({tag, ".pc_plus4_d"},  pc_plus4_d,   32'(mPcP4));
    check({tag, ".valid_d"},     32'(valid_d), 32'(mValid));
    check({tag, ".misalign"},    32'(misalign_err), 32'(mErr));
    check({tag, ".err_pc"},      err_pc,       32'(mErrPc));
    check({tag, ".fetch_count"}, fetch_count,  32'(mCount));
  endtask

  // Apply inputs, advance one edge, update the model from the rules, then compare.
  task automatic step(input string tag, input bit r, input logic [1:0] src,
                      input logic [31:0] bt, input logic [31:0] alu, input bit st);
    longint unsigned tgt;
    logic [31:0]     fetched;
    bit              redir;
    rst = r; PCsrc = src; branch_target = bt; alu_result = alu; stall = st;
    fetched = useConst ? constWord : romWord(32'(mPc));
    @(posedge clk);
    #1;
    redir = (src == 2'd1) || (src == 2'd2);
    tgt   = (src == 2'd1) ? longint'(bt) : (longint'(alu) / 2) * 2;
    if (r) begin
      mPc = RPC; mInstr = NOP; mPcD = 0; mPcP4 = 0; mValid = 0;
      mErr = 0; mErrPc = 0; mCount = 0;
    end else if (redir) begin
      if ((tgt % 4) >= 2 && !mErr) begin
        mErr = 1; mErrPc = tgt;
      end
      mPc = tgt - (tgt % 4);
      mInstr = NOP; mValid = 0;
    end else if (!st) begin
      mInstr = fetched;
      mPcD   = mPc;
      mPcP4  = (mPc + 4) % (64'd1 << 32);
      mPc    = mPcP4;
      mValid = 1;
      mCount = (mCount + 1) % (64'd1 << 32);
    end
    checkModel(tag);
  endtask

  logic [31:0] holdPc, holdInstr, holdCount;

  initial begin
    rst = 1'b1; PCsrc = 2'd0; branch_target = '0; alu_result = '0; stall = 1'b0;
    mPc = 0; mPcD = 0; mPcP4 = 0; mErrPc = 0; mCount = 0; mInstr = 0; mValid = 0; mErr = 0;

    // Reset state
    step("reset", 1, 0, 0, 0, 0);
    check("reset.pc_f", pc_f, 32'hBFC00000);
    check("reset.instr_d", instr_d, 32'h00000013);

    // Three sequential fetches of a constant word
    repeat (3) step("seq", 0, 0, 0, 0, 0);
    check("seq3.pc_f", pc_f, 32'hBFC0000C);
    check("seq3.pc_d", pc_d, 32'hBFC00008);
    check("seq3.pc_plus4_d", pc_plus4_d, 32'hBFC0000C);
    check("seq3.instr_d", instr_d, 32'h00A00093);
    check("seq3.count", fetch_count, 32'd3);

    // Branch taken while fetching BFC00008
    step("rst2", 1, 0, 0, 0, 0);
    repeat (2) step("seq2", 0, 0, 0, 0, 0);
    check("br.pre_pc", pc_f, 32'hBFC00008);
    step("branch", 0, 1, 32'hBFC00100, 0, 0);
    check("br.pc_f", pc_f, 32'hBFC00100);
    check("br.valid", 32'(valid_d), 32'd0);
    check("br.count", fetch_count, 32'd2);
    step("br.after", 0, 0, 0, 0, 0);
    check("br.after.valid", 32'(valid_d), 32'd1);

    // jalr alignment and sticky misalignment capture
    step("jalr205", 0, 2, 0, 32'h00000205, 0);
    check("jalr205.pc", pc_f, 32'h00000204);
    check("jalr205.err", 32'(misalign_err), 32'd0);
    step("jalr306", 0, 2, 0, 32'h00000306, 0);
    check("jalr306.pc", pc_f, 32'h00000304);
    check("jalr306.err", 32'(misalign_err), 32'd1);
    check("jalr306.err_pc", err_pc, 32'h00000306);
    step("br0A", 0, 1, 32'h0000000A, 0, 0);
    check("br0A.err_pc", err_pc, 32'h00000306);
    check("br0A.pc", pc_f, 32'h00000008);

    // Stall holds everything; redirect overrides stall
    useConst = 1'b0;
    step("prestall", 0, 0, 0, 0, 0);
    holdPc = pc_f; holdInstr = instr_d; holdCount = fetch_count;
    repeat (4) step("stall", 0, 0, 0, 0, 1);
    check("stall.pc", pc_f, holdPc);
    check("stall.instr", instr_d, holdInstr);
    check("stall.count", fetch_count, holdCount);
    step("stall_br", 0, 1, 32'h00000040, 0, 1);
    check("stall_br.pc", pc_f, 32'h00000040);
    check("stall_br.valid", 32'(valid_d), 32'd0);

    // PC wraparound
    step("to_top", 0, 1, 32'hFFFFFFFC, 0, 0);
    step("wrap", 0, 0, 0, 0, 0);
    check("wrap.pc", pc_f, 32'h00000000);
    check("wrap.pc_d", pc_d, 32'hFFFFFFFC);
    check("wrap.pc_plus4_d", pc_plus4_d, 32'h00000000);

    // Reset overrides stall and redirect
    step("rst_ovr", 1, 1, 32'h00001000, 0, 1);
    check("rst_ovr.pc", pc_f, 32'hBFC00000);
    check("rst_ovr.valid", 32'(valid_d), 32'd0);
    check("rst_ovr.err", 32'(misalign_err), 32'd0);
    check("rst_ovr.count", fetch_count, 32'd0);

    // Random traffic, including the reserved PCsrc encoding
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  src;
      logic [31:0] bt, alu;
      bit          st, r;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      src = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      bt  = $urandom;
      alu = $urandom;
      st  = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 99) == 0);
      step("rand", r, src, bt, alu, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
